led_peripheral: RTL and testbench

LED_PERIPHERAL -- requirements
Module: led_peripheral

---
 rtl/led_peripheral.sv | 144 ++++++++++++++
 tb/tb_led_peripheral.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_peripheral.sv
// LED peripheral: memory-mapped LED register with an optional blink and
// rotate pattern driven by a programmable prescaler tick.
//   0x0 LED    RW  [NUM_LEDS-1:0]
//   0x4 CTRL   RW  bit0 blink_en, bit1 rot_en
//   0x8 PERIOD RW  [23:0] tick period in clock cycles (0 behaves as 1)
//   0xC TICKS  RO  [7:0]  free-running tick counter
`timescale 1ns/1ps

module led_peripheral #(
  parameter int          NUM_LEDS       = 8,
  parameter logic [23:0] DEFAULT_PERIOD = 24'd50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en_i,
  input  logic                wr_en_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic [NUM_LEDS-1:0] leds_o
);

  logic [NUM_LEDS-1:0] r_led;
  logic                r_blinkEn;
  logic                r_rotEn;
  logic [23:0]         r_period;
  logic [23:0]         r_prescaler;
  logic [7:0]          r_ticks;
  logic                r_phase;

  logic                w_wrLed;
  logic                w_wrCtrl;
  logic                w_wrPeriod;
  logic [23:0]         w_lastCount;
  logic                w_tick;
  logic [NUM_LEDS-1:0] w_rotated;
  logic                w_unused;

  // Only addr_i[3:2] select a register; everything else on the bus is don't-care.
  assign w_unused   = ^{addr_i[31:4], addr_i[1:0], data_i[31:24]};

  assign w_wrLed    = wr_en_i && (addr_i[3:2] == 2'd0);
  assign w_wrCtrl   = wr_en_i && (addr_i[3:2] == 2'd1);
  assign w_wrPeriod = wr_en_i && (addr_i[3:2] == 2'd2);

  // A zero period is treated as one so the prescaler still produces a tick every cycle.
  assign w_lastCount = (r_period == 24'd0) ? 24'd0 : (r_period - 24'd1);

  // A PERIOD write restarts the count, so it must never coincide with a tick.
  assign w_tick = (r_prescaler == w_lastCount) && !w_wrPeriod;

  // Rotate left by one with the MSB wrapping into bit 0; written as a loop so NUM_LEDS=1 works.
  always_comb begin
    w_rotated = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_rotated[(i + 1) % NUM_LEDS] = r_led[i];
    end
  end

  // Combinational read mux; reads see the pre-write value when a write happens in the same cycle.
  always_comb begin
    data_o = 32'h0;
    if (rd_en_i) begin
      case (addr_i[3:2])
        2'd0: data_o[NUM_LEDS-1:0] = r_led;
        2'd1: data_o[1:0]          = {r_rotEn, r_blinkEn};
        2'd2: data_o[23:0]         = r_period;
        2'd3: data_o[7:0]          = r_ticks;
        default: data_o = 32'h0;
      endcase
    end
  end

  // LED register: a bus write takes priority over a rotate on the same tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_wrLed) begin
      r_led <= data_i[NUM_LEDS-1:0];
    end else if (w_tick && r_rotEn) begin
      r_led <= w_rotated;
    end
  end

  // CTRL and PERIOD registers, plain bus-written state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blinkEn <= 1'b0;
      r_rotEn   <= 1'b0;
      r_period  <= DEFAULT_PERIOD;
    end else begin
      if (w_wrCtrl) begin
        r_blinkEn <= data_i[0];
        r_rotEn   <= data_i[1];
      end
      if (w_wrPeriod) begin
        r_period <= data_i[23:0];
      end
    end
  end

  // Prescaler counts 0..P-1 and restarts on wrap or on any PERIOD write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler <= 24'd0;
    end else if (w_wrPeriod || (r_prescaler >= w_lastCount)) begin
      r_prescaler <= 24'd0;
    end else begin
      r_prescaler <= r_prescaler + 24'd1;
    end
  end

  // Tick counter, wraps silently at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ticks <= 8'd0;
    end else if (w_tick) begin
      r_ticks <= r_ticks + 8'd1;
    end
  end

  // Blink phase: disabling blink parks the phase in the "LEDs on" state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 1'b1;
    end else if (w_wrCtrl && !data_i[0]) begin
      r_phase <= 1'b1;
    end else if (w_tick && r_blinkEn) begin
      r_phase <= ~r_phase;
    end
  end

  // Registered LED drive, one cycle behind the register/phase state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_o <= '0;
    end else if (!r_blinkEn || r_phase) begin
      leds_o <= r_led;
    end else begin
      leds_o <= '0;
    end
  end

endmodule

// File: tb/tb_led_peripheral.sv
// Self-checking bench for led_peripheral: a register-access vector table
// followed by hand-written multi-cycle sequences for rotate, blink,
// zero period, TICKS wrap and asynchronous reset.
`timescale 1ns/1ps

module tb_led_peripheral;

  logic        clk;
  logic        rst;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dataOut;
  logic [7:0]  leds;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic [7:0]  expLeds;
  } vec_t;

  vec_t vecs[24];

  led_peripheral #(
    .NUM_LEDS      (8),
    .DEFAULT_PERIOD(24'd50)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rd_en_i(rdEn),
    .wr_en_i(wrEn),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (dataOut),
    .leds_o (leds)
  );

  // 20 ns clock; inputs change on the falling edge, outputs are sampled 1 ns later.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference rotate-left used to predict LED patterns.
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Drive one bus cycle at the falling edge and settle before sampling.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rdEn  = rd;
    wrEn  = wr;
    addr  = a;
    wdata = d;
    #1;
  endtask

  // One comparison: count it, and report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Synchronous-looking reset pulse with idle bus.
  task automatic doReset();
    @(negedge clk);
    rst  = 1'b1;
    rdEn = 1'b0;
    wrEn = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    rdEn  = 1'b0;
    wrEn  = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;

    // Register access table; each row is one cycle, expectations are pre-edge.
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0032, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_00A5, 32'h0000_0000, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_00A5, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_FFF3, 32'h0,         32'h0000_00A5, 8'hA5};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0000, 8'hA5};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 8'hA5};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0003, 32'h0000_0000, 8'hA5};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0003, 8'hA5};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 8'hA5};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 8'hA5};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_000C, 32'h0000_0055, 32'h0000_0000, 8'hA5};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000, 8'hA5};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0007, 32'h0000_0032, 8'hA5};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0007, 8'hA5};
    for (int i = 17; i < 23; i++) vecs[i] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 8'hA5};
    vecs[23] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         32'h0000_0001, 8'hA5};

    doReset();
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d data_o", i), dataOut, vecs[i].expData);
      checkOutput($sformatf("vec%0d leds_o", i), {24'h0, leds}, {24'h0, vecs[i].expLeds});
    end

    // Rotate: LED=0x81, rot_en, PERIOD=4 written last so the count starts there.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h81);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h2);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h4);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("rot k%0d LED", k), dataOut, {24'h0, rotl8(8'h81, (k - 1) / 4)});
      checkOutput($sformatf("rot k%0d leds_o", k), {24'h0, leds}, {24'h0, rotl8(8'h81, (k - 2) / 4)});
    end
    for (int k = 10; k <= 13; k++) begin
      applyStimulus(1'b1, 1'b0, 32'hC, 32'h0);
      checkOutput($sformatf("rot k%0d TICKS", k), dataOut, 32'((k - 1) / 4));
    end

    // Blink: LED=0xFF, blink_en, PERIOD=3; leds_o toggles every 3 cycles.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hFF);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h3);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("blink k%0d leds_o", k), {24'h0, leds},
                  ((((k - 2) / 3) % 2) == 0) ? 32'hFF : 32'h00);
    end
    checkOutput("blink LED reg", dataOut, 32'hFF);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0);
    checkOutput("blink off leds_o", {24'h0, leds}, 32'hFF);
    checkOutput("blink off CTRL", dataOut, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("blink off leds_o hold", {24'h0, leds}, 32'hFF);

    // PERIOD=0: tick every cycle; a LED write on a tick edge is not rotated.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h2);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("p0 k%0d LED", k), dataOut, 32'h1 << (k - 1));
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h10);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("p0 write wins", dataOut, 32'h10);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("p0 rotate after", dataOut, 32'h20);
    applyStimulus(1'b1, 1'b0, 32'hC, 32'h0);
    checkOutput("p0 TICKS", dataOut, 32'h6);

    // TICKS wrap 0xFF -> 0x00 with a tick every cycle.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h0);
    for (int k = 1; k <= 257; k++) begin
      applyStimulus(1'b1, 1'b0, 32'hC, 32'h0);
      if (k == 1 || k == 256 || k == 257) begin
        checkOutput($sformatf("wrap k%0d TICKS", k), dataOut, 32'((k - 1) % 256));
      end
    end

    // Asynchronous reset mid-blink, checked between clock edges.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h5A);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h2);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
      if (k == 4) checkOutput("arst pre dark", {24'h0, leds}, 32'h00);
      if (k == 6) checkOutput("arst pre lit", {24'h0, leds}, 32'h5A);
    end
    #1 rst = 1'b1;
    #1 checkOutput("arst leds_o", {24'h0, leds}, 32'h0);
    rdEn = 1'b1;
    addr = 32'h0;
    #1 checkOutput("arst LED", dataOut, 32'h0);
    addr = 32'h4;
    #1 checkOutput("arst CTRL", dataOut, 32'h0);
    addr = 32'h8;
    #1 checkOutput("arst PERIOD", dataOut, 32'h32);
    addr = 32'hC;
    #1 checkOutput("arst TICKS", dataOut, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("arst held leds_o", {24'h0, leds}, 32'h0);
    rst = 1'b0;
    rdEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
